mem_dbus_master: RTL and testbench
==================================

// Module: mem_dbus_master
// PURPOSE
// MEM-stage data-bus master: consumes the EX/MEM register outputs (aluop, address, store data, wd/wreg/wdata) and runs load/store accesses on a
// req/ack data bus. Holds the pipeline through stallreq_o until ack arrives, then hands aligned, extended load data toward MEM/WB.
// Big-endian byte lanes; misaligned accesses are flagged as address errors and never reach the bus.
// PARAMETERS
// TIMEOUT_CYCLES  255  BUSY cycles without ack before bus error is raised (1..255)
// PORTS
// clk           in   1   clock, all state on rising edge
// rst           in   1   synchronous reset, active-high
// stall_i       in   6   pipeline stall vector; stall_i[4]==0 means MEM/WB captures this cycle
// flush_i       in   1   pipeline flush (exception)
// mem_aluop_i   in   8   op: LB,LBU,LH,LHU,LW,SB,SH,SW memory ops; any other op = non-memory
// mem_addr_i    in   32  effective address
// mem_reg2_i    in   32  store data
// mem_wd_i      in   5   dest register; mem_wreg_i in 1 write enable; mem_wdata_i in 32 ALU result
// wb_wd_o       out  5   to MEM/WB; wb_wreg_o out 1; wb_wdata_o out 32
// stallreq_o    out  1   stall request to pipeline control
// ale_o / ase_o out  1   load / store address-error (misaligned), combinational
// bus_err_o     out  1   one-cycle pulse on ack timeout
// dbus_req_o    out  1   registered request; dbus_we_o out 1; dbus_addr_o out 32 (word-aligned, [1:0]=0)
// dbus_sel_o    out  4   byte enables, sel[3]=bits[31:24]; dbus_wdata_o out 32
// dbus_ack_i    in   1   transfer complete; dbus_rdata_i in 32 read data, valid with ack
// BEHAVIOUR
// - Reset: state IDLE, counter 0, all dbus_* outputs 0, bus_err_o 0, latched rdata 0.
// - States: IDLE, BUSY, DONE, ABORT. memop = mem_aluop_i is a load/store; mis = LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
// - IDLE: non-memop -> wb_* = mem_wd/wreg/wdata passthrough, stallreq_o=0.
//   memop & mis -> ale_o (loads) / ase_o (stores) =1, wb_wreg_o=0, no request, stay IDLE.
//   memop & !mis & !flush_i -> stallreq_o=1; next edge: BUSY, latch addr/sel/we/wdata onto dbus_*, dbus_req_o=1, counter=0.
// - Lanes: byte at addr[1:0]=00 -> sel 1000 ... 11 -> sel 0001; half addr[1]=0 -> 1100, =1 -> 0011; word -> 1111.
//   SB wdata = {4{reg2[7:0]}}; SH = {2{reg2[15:0]}}; SW = reg2.
// - BUSY: stallreq_o=1, dbus_* held stable. Ack -> latch dbus_rdata_i, dbus_req_o=0, -> DONE. Counter increments each cycle without ack;
//   reaching TIMEOUT_CYCLES -> bus_err_o=1 for one cycle, req dropped, latched data 0, writeback suppressed, -> DONE.
//   flush_i (no ack) -> ABORT. Ack and flush_i same cycle -> ack wins, then flush handled as in DONE.
// - DONE: stallreq_o=0; loads: wb_wdata_o = selected byte/half of latched data, sign-extend LB/LH, zero-extend LBU/LHU, LW whole word;
//   wb_wreg_o = mem_wreg_i (0 after timeout); stores: wb_wreg_o=0. -> IDLE on edge with stall_i[4]==0 or flush_i.
//   No second request is ever issued for the same instruction.
// - ABORT: dbus_req_o held until ack or timeout (no bus_err_o pulse), stallreq_o=1, wb_wreg_o=0; then -> IDLE.
// - ale_o/ase_o/stallreq_o are combinational from state + inputs; wb_* combinational; all dbus_* registered.
// - Reset mid-transaction: IDLE next cycle, req dropped; a late ack is ignored.
// TESTING
// - LW addr 0x100, ack after 3 cycles, rdata 0x11223344 -> stallreq 4 cycles, sel 1111, wb_wdata 0x11223344, one request only.
// - LB addr 0x103 rdata 0x000000F0 -> sel 0001, wb_wdata 0xFFFFFFF0; LBU same -> 0x000000F0; LH addr 0x102 rdata 0x00008001 -> 0xFFFF8001.
// - SH addr 0x202 reg2 0xAAAA1234 -> we=1, addr 0x200, sel 0011, wdata 0x12341234, wb_wreg 0.
// - LW addr 0x101 -> ale_o=1, no dbus_req, stallreq 0; SH addr 0x201 -> ase_o=1.
// - No ack, TIMEOUT_CYCLES=4 -> bus_err_o pulses once, req drops, wb_wreg 0, stall released.
// - flush_i in BUSY cycle 1, ack at cycle 3 -> ABORT, no writeback, IDLE after ack; DONE held while stall_i[4]=1, exits when 0.

Source files
------------

// File: rtl/mem_dbus_if.sv
// Data-bus bundle between the MEM-stage master and the memory/slave side.
// The request and its qualifiers come from the master; the slave answers with ack and read data.
interface mem_dbus_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  sel;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, we, addr, sel, wdata, input ack, rdata);
  modport slave  (input req, we, addr, sel, wdata, output ack, rdata);
endinterface

// File: rtl/mem_dbus_master.sv
// MEM-stage data-bus master: issues one req/ack access per load/store, stalls the pipeline
// until it completes, and returns aligned, extended load data toward MEM/WB (big-endian lanes).
module mem_dbus_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall_i,
  input  logic        flush_i,
  input  logic [7:0]  mem_aluop_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] mem_reg2_i,
  input  logic [4:0]  mem_wd_i,
  input  logic        mem_wreg_i,
  input  logic [31:0] mem_wdata_i,
  output logic [4:0]  wb_wd_o,
  output logic        wb_wreg_o,
  output logic [31:0] wb_wdata_o,
  output logic        stallreq_o,
  output logic        ale_o,
  output logic        ase_o,
  output logic        bus_err_o,
  mem_dbus_if.master  dbus
);

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2, S_ABORT = 2'd3} state_e;

  state_e      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [3:0]  sel_q, sel_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        bus_err_q, bus_err_d;
  logic [7:0]  op_q, op_d;
  logic [1:0]  lo_q, lo_d;
  logic        to_q, to_d;

  logic        is_load, is_store, mis;
  logic [3:0]  sel_new;
  logic [31:0] wdata_new;
  logic        unused_stall_bits;

  assign unused_stall_bits = ^{stall_i[5], stall_i[3:0]};

  // Pick the addressed byte/half out of the big-endian word and extend it.
  function automatic logic [31:0] load_data(input logic [7:0] op, input logic [1:0] lo,
                                            input logic [31:0] d);
    logic [7:0]  b;
    logic [15:0] h;
    case (lo)
      2'b00:   b = d[31:24];
      2'b01:   b = d[23:16];
      2'b10:   b = d[15:8];
      default: b = d[7:0];
    endcase
    h = lo[1] ? d[15:0] : d[31:16];
    case (op)
      OP_LB:   load_data = {{24{b[7]}}, b};
      OP_LBU:  load_data = {24'h00_0000, b};
      OP_LH:   load_data = {{16{h[15]}}, h};
      OP_LHU:  load_data = {16'h0000, h};
      OP_LW:   load_data = d;
      default: load_data = 32'h0000_0000;
    endcase
  endfunction

  // Decode the op into direction, alignment fault, byte enables and replicated store data.
  always_comb begin
    is_load   = 1'b0;
    is_store  = 1'b0;
    mis       = 1'b0;
    sel_new   = 4'b0000;
    wdata_new = 32'h0000_0000;
    case (mem_aluop_i)
      OP_LB, OP_LBU: begin
        is_load = 1'b1;
        sel_new = 4'b1000 >> mem_addr_i[1:0];
      end
      OP_LH, OP_LHU: begin
        is_load = 1'b1;
        mis     = mem_addr_i[0];
        sel_new = mem_addr_i[1] ? 4'b0011 : 4'b1100;
      end
      OP_LW: begin
        is_load = 1'b1;
        mis     = |mem_addr_i[1:0];
        sel_new = 4'b1111;
      end
      OP_SB: begin
        is_store  = 1'b1;
        sel_new   = 4'b1000 >> mem_addr_i[1:0];
        wdata_new = {4{mem_reg2_i[7:0]}};
      end
      OP_SH: begin
        is_store  = 1'b1;
        mis       = mem_addr_i[0];
        sel_new   = mem_addr_i[1] ? 4'b0011 : 4'b1100;
        wdata_new = {2{mem_reg2_i[15:0]}};
      end
      OP_SW: begin
        is_store  = 1'b1;
        mis       = |mem_addr_i[1:0];
        sel_new   = 4'b1111;
        wdata_new = mem_reg2_i;
      end
      default: begin
        is_load = 1'b0;
      end
    endcase
  end

  // Next-state and pipeline-facing outputs of the transfer FSM.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    sel_d      = sel_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    bus_err_d  = 1'b0;
    op_d       = op_q;
    lo_d       = lo_q;
    to_d       = to_q;
    stallreq_o = 1'b0;
    ale_o      = 1'b0;
    ase_o      = 1'b0;
    wb_wd_o    = mem_wd_i;
    wb_wreg_o  = mem_wreg_i;
    wb_wdata_o = mem_wdata_i;
    case (state_q)
      S_IDLE: begin
        if (is_load || is_store) begin
          wb_wreg_o = 1'b0;
          if (mis) begin
            ale_o = is_load;
            ase_o = is_store;
          end else if (!flush_i) begin
            stallreq_o = 1'b1;
            state_d    = S_BUSY;
            req_d      = 1'b1;
            we_d       = is_store;
            addr_d     = {mem_addr_i[31:2], 2'b00};
            sel_d      = sel_new;
            wdata_d    = wdata_new;
            cnt_d      = 8'd0;
            op_d       = mem_aluop_i;
            lo_d       = mem_addr_i[1:0];
            to_d       = 1'b0;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        stallreq_o = 1'b1;
        wb_wreg_o  = 1'b0;
        // A coincident flush loses to ack; the DONE state then sees the flush.
        if (dbus.ack) begin
          rdata_d = dbus.rdata;
          req_d   = 1'b0;
          state_d = S_DONE;
        end else if (cnt_q == TO_LAST) begin
          bus_err_d = 1'b1;
          req_d     = 1'b0;
          rdata_d   = 32'h0000_0000;
          to_d      = 1'b1;
          state_d   = S_DONE;
        end else if (flush_i) begin
          cnt_d   = cnt_q + 8'd1;
          state_d = S_ABORT;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DONE: begin
        if (!we_q) begin
          wb_wdata_o = load_data(op_q, lo_q, rdata_q);
          wb_wreg_o  = mem_wreg_i & ~to_q;
        end else begin
          wb_wreg_o = 1'b0;
        end
        if (!stall_i[4] || flush_i) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      S_ABORT: begin
        stallreq_o = 1'b1;
        wb_wreg_o  = 1'b0;
        if (dbus.ack || (cnt_q == TO_LAST)) begin
          req_d   = 1'b0;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        req_d   = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  // State and bus-facing registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 8'd0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= 32'h0000_0000;
      sel_q     <= 4'b0000;
      wdata_q   <= 32'h0000_0000;
      rdata_q   <= 32'h0000_0000;
      bus_err_q <= 1'b0;
      op_q      <= 8'h00;
      lo_q      <= 2'b00;
      to_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      sel_q     <= sel_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      bus_err_q <= bus_err_d;
      op_q      <= op_d;
      lo_q      <= lo_d;
      to_q      <= to_d;
    end
  end

  assign bus_err_o  = bus_err_q;
  assign dbus.req   = req_q;
  assign dbus.we    = we_q;
  assign dbus.addr  = addr_q;
  assign dbus.sel   = sel_q;
  assign dbus.wdata = wdata_q;

endmodule

// File: tb/tb_mem_dbus_master.sv
// Bench for mem_dbus_master: table of load/store vectors against a bus responder with
// per-vector ack latency, plus hand-written timeout, flush, ack+flush and reset sequences.
module tb_mem_dbus_master;

  localparam logic [7:0] OP_LB  = 8'b1110_0000;
  localparam logic [7:0] OP_LH  = 8'b1110_0001;
  localparam logic [7:0] OP_LW  = 8'b1110_0011;
  localparam logic [7:0] OP_LBU = 8'b1110_0100;
  localparam logic [7:0] OP_LHU = 8'b1110_0101;
  localparam logic [7:0] OP_SB  = 8'b1110_1000;
  localparam logic [7:0] OP_SH  = 8'b1110_1001;
  localparam logic [7:0] OP_SW  = 8'b1110_1011;
  localparam logic [7:0] OP_NOP = 8'h00;
  localparam logic [5:0] STALL_MEM = 6'b01_1111;

  typedef struct {
    logic [7:0]  op;
    logic [31:0] addr;
    logic [31:0] reg2;
    logic [31:0] rdata;
    int          lat;
    logic        mis;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] baddr;
    logic [31:0] bwdata;
    logic [31:0] wbd;
    logic        wbr;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stall_i;
  logic        flush_i;
  logic [7:0]  mem_aluop_i;
  logic [31:0] mem_addr_i;
  logic [31:0] mem_reg2_i;
  logic [4:0]  mem_wd_i;
  logic        mem_wreg_i;
  logic [31:0] mem_wdata_i;
  logic [4:0]  wb_wd_o;
  logic        wb_wreg_o;
  logic [31:0] wb_wdata_o;
  logic        stallreq_o;
  logic        ale_o;
  logic        ase_o;
  logic        bus_err_o;

  int n_checks = 0;
  int n_err = 0;
  vec_t vecs[$];
  vec_t exp_q[$];

  mem_dbus_if dbus ();

  mem_dbus_master #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i), .flush_i(flush_i),
    .mem_aluop_i(mem_aluop_i), .mem_addr_i(mem_addr_i), .mem_reg2_i(mem_reg2_i),
    .mem_wd_i(mem_wd_i), .mem_wreg_i(mem_wreg_i), .mem_wdata_i(mem_wdata_i),
    .wb_wd_o(wb_wd_o), .wb_wreg_o(wb_wreg_o), .wb_wdata_o(wb_wdata_o),
    .stallreq_o(stallreq_o), .ale_o(ale_o), .ase_o(ase_o), .bus_err_o(bus_err_o),
    .dbus(dbus)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic vec_t mk(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                              input logic [31:0] rdata, input int lat, input logic mis, input logic we,
                              input logic [3:0] sel, input logic [31:0] baddr, input logic [31:0] bwdata,
                              input logic [31:0] wbd, input logic wbr);
    vec_t v;
    v.op = op; v.addr = addr; v.reg2 = reg2; v.rdata = rdata; v.lat = lat; v.mis = mis;
    v.we = we; v.sel = sel; v.baddr = baddr; v.bwdata = bwdata; v.wbd = wbd; v.wbr = wbr;
    return v;
  endfunction

  task automatic run_vec(input vec_t v);
    vec_t e;
    int   busy = 0;
    int   nstall = 0;
    int   nreq = 0;
    bit   done = 1'b0;
    logic prev_req = 1'b0;
    tick();
    mem_aluop_i = v.op; mem_addr_i = v.addr; mem_reg2_i = v.reg2;
    mem_wdata_i = 32'h5A5A_0000; stall_i = STALL_MEM;
    exp_q.push_back(v);
    #1;
    if (v.mis) begin
      e = exp_q.pop_front();
      chk("mis_ale", 32'(ale_o), 32'(!e.we));
      chk("mis_ase", 32'(ase_o), 32'(e.we));
      chk("mis_stallreq", 32'(stallreq_o), 32'd0);
      chk("mis_wreg", 32'(wb_wreg_o), 32'd0);
      tick(); #1;
      chk("mis_no_req", 32'(dbus.req), 32'd0);
    end else begin
      for (int c = 0; c < 20 && !done; c++) begin
        if (stallreq_o) nstall++;
        if (dbus.req) begin
          if (!prev_req) begin
            nreq++;
            chk("bus_sel", 32'(dbus.sel), 32'(v.sel));
            chk("bus_we", 32'(dbus.we), 32'(v.we));
            chk("bus_addr", dbus.addr, v.baddr);
            if (v.we) chk("bus_wdata", dbus.wdata, v.bwdata);
          end
          busy++;
        end
        prev_req = dbus.req;
        if (busy > 0 && !stallreq_o) begin
          e = exp_q.pop_front();
          if (!e.we) chk("wb_wdata", wb_wdata_o, e.wbd);
          chk("wb_wreg", 32'(wb_wreg_o), 32'(e.wbr));
          chk("wb_wd", 32'(wb_wd_o), 32'd9);
          chk("stall_cycles", nstall, e.lat + 1);
          chk("one_request", nreq, 1);
          chk("req_dropped", 32'(dbus.req), 32'd0);
          stall_i = 6'b00_0000;
          dbus.ack = 1'b0;
          done = 1'b1;
        end else begin
          dbus.ack   = dbus.req && (busy == v.lat);
          dbus.rdata = dbus.ack ? v.rdata : 32'hDEAD_BEEF;
          tick(); #1;
        end
      end
      chk("done_reached", 32'(done), 32'd1);
    end
    tick();
    mem_aluop_i = OP_NOP; stall_i = 6'b00_0000; dbus.ack = 1'b0;
  endtask

  initial begin
    int nst = 0;
    int npulse = 0;
    int nreqc = 0;
    rst = 1'b1; stall_i = 6'b00_0000; flush_i = 1'b0; mem_aluop_i = OP_NOP;
    mem_addr_i = 32'h0; mem_reg2_i = 32'h0; mem_wd_i = 5'd9; mem_wreg_i = 1'b1;
    mem_wdata_i = 32'h1357_9BDF; dbus.ack = 1'b0; dbus.rdata = 32'h0;

    vecs.push_back(mk(OP_LW,  32'h100, 32'h0, 32'h1122_3344, 3, 1'b0, 1'b0, 4'b1111, 32'h100, 32'h0, 32'h1122_3344, 1'b1));
    vecs.push_back(mk(OP_LB,  32'h103, 32'h0, 32'h0000_00F0, 1, 1'b0, 1'b0, 4'b0001, 32'h100, 32'h0, 32'hFFFF_FFF0, 1'b1));
    vecs.push_back(mk(OP_LBU, 32'h103, 32'h0, 32'h0000_00F0, 2, 1'b0, 1'b0, 4'b0001, 32'h100, 32'h0, 32'h0000_00F0, 1'b1));
    vecs.push_back(mk(OP_LH,  32'h102, 32'h0, 32'h0000_8001, 1, 1'b0, 1'b0, 4'b0011, 32'h100, 32'h0, 32'hFFFF_8001, 1'b1));
    vecs.push_back(mk(OP_LHU, 32'h100, 32'h0, 32'h8001_1234, 2, 1'b0, 1'b0, 4'b1100, 32'h100, 32'h0, 32'h0000_8001, 1'b1));
    vecs.push_back(mk(OP_LB,  32'h101, 32'h0, 32'h1285_5678, 1, 1'b0, 1'b0, 4'b0100, 32'h100, 32'h0, 32'hFFFF_FF85, 1'b1));
    vecs.push_back(mk(OP_LBU, 32'h202, 32'h0, 32'h1122_7F44, 1, 1'b0, 1'b0, 4'b0010, 32'h200, 32'h0, 32'h0000_007F, 1'b1));
    vecs.push_back(mk(OP_SH,  32'h202, 32'hAAAA_1234, 32'h0, 2, 1'b0, 1'b1, 4'b0011, 32'h200, 32'h1234_1234, 32'h0, 1'b0));
    vecs.push_back(mk(OP_SB,  32'h305, 32'h0000_00A5, 32'h0, 1, 1'b0, 1'b1, 4'b0100, 32'h304, 32'hA5A5_A5A5, 32'h0, 1'b0));
    vecs.push_back(mk(OP_SW,  32'h40C, 32'hCAFE_F00D, 32'h0, 4, 1'b0, 1'b1, 4'b1111, 32'h40C, 32'hCAFE_F00D, 32'h0, 1'b0));
    vecs.push_back(mk(OP_LW,  32'h101, 32'h0, 32'h0, 0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(OP_SH,  32'h201, 32'h0, 32'h0, 0, 1'b1, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(OP_SW,  32'h402, 32'h0, 32'h0, 0, 1'b1, 1'b1, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0));
    vecs.push_back(mk(OP_LHU, 32'h7FF, 32'h0, 32'h0, 0, 1'b1, 1'b0, 4'b0000, 32'h0, 32'h0, 32'h0, 1'b0));

    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(dbus.req), 32'd0);
    chk("rst_we", 32'(dbus.we), 32'd0);
    chk("rst_addr", dbus.addr, 32'd0);
    chk("rst_sel", 32'(dbus.sel), 32'd0);
    chk("rst_wdata", dbus.wdata, 32'd0);
    chk("rst_bus_err", 32'(bus_err_o), 32'd0);
    tick();
    rst = 1'b0;
    #1;
    chk("nop_wdata", wb_wdata_o, 32'h1357_9BDF);
    chk("nop_wreg", 32'(wb_wreg_o), 32'd1);
    chk("nop_stallreq", 32'(stallreq_o), 32'd0);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Ack timeout: 4 BUSY cycles, one bus_err pulse, DONE held while stall_i[4]=1.
    tick();
    mem_aluop_i = OP_LW; mem_addr_i = 32'h500; stall_i = STALL_MEM;
    for (int c = 0; c < 10; c++) begin
      if (c == 7) mem_aluop_i = OP_NOP;
      #1;
      if (stallreq_o) nst++;
      if (bus_err_o) npulse++;
      if (dbus.req) nreqc++;
      if (c == 5) begin
        chk("to_err_at_done", 32'(bus_err_o), 32'd1);
        chk("to_wreg", 32'(wb_wreg_o), 32'd0);
        chk("to_req_drop", 32'(dbus.req), 32'd0);
      end
      if (c == 6) begin
        chk("to_done_hold", 32'(stallreq_o), 32'd0);
        stall_i = 6'b00_0000;
      end
      tick();
    end
    chk("to_stall_cycles", nst, 5);
    chk("to_pulses", npulse, 1);
    chk("to_req_cycles", nreqc, 4);

    // Flush in first BUSY cycle, ack on third bus cycle.
    nreqc = 0; npulse = 0;
    mem_aluop_i = OP_LW; mem_addr_i = 32'h600; stall_i = STALL_MEM;
    for (int c = 0; c < 7; c++) begin
      if (c == 2) begin flush_i = 1'b0; mem_aluop_i = OP_NOP; end
      if (c == 3) begin dbus.ack = 1'b1; dbus.rdata = 32'h7777_7777; end
      if (c == 4) dbus.ack = 1'b0;
      #1;
      if (dbus.req) nreqc++;
      if (bus_err_o) npulse++;
      if (c == 1) flush_i = 1'b1;
      if (c == 2 || c == 3) begin
        chk("abort_stallreq", 32'(stallreq_o), 32'd1);
        chk("abort_wreg", 32'(wb_wreg_o), 32'd0);
      end
      if (c == 4) begin
        chk("abort_exit_stall", 32'(stallreq_o), 32'd0);
        chk("abort_exit_wreg", 32'(wb_wreg_o), 32'd1);
      end
      tick();
    end
    chk("abort_req_cycles", nreqc, 3);
    chk("abort_no_err", npulse, 0);

    // Ack and flush together: data still delivered, flush then leaves DONE.
    mem_aluop_i = OP_LW; mem_addr_i = 32'h700; stall_i = STALL_MEM;
    tick();
    dbus.ack = 1'b1; dbus.rdata = 32'h0BAD_F00D; flush_i = 1'b1;
    #1;
    chk("af_req", 32'(dbus.req), 32'd1);
    tick();
    dbus.ack = 1'b0; dbus.rdata = 32'hDEAD_BEEF;
    #1;
    chk("af_wdata", wb_wdata_o, 32'h0BAD_F00D);
    chk("af_wreg", 32'(wb_wreg_o), 32'd1);
    chk("af_stallreq", 32'(stallreq_o), 32'd0);
    tick();
    flush_i = 1'b0; mem_aluop_i = OP_LH; mem_addr_i = 32'h101;
    #1;
    chk("af_exit_idle", 32'(ale_o), 32'd1);
    tick();
    mem_aluop_i = OP_NOP; stall_i = 6'b00_0000;

    // Reset mid-transaction, then a late ack.
    tick();
    mem_aluop_i = OP_LW; mem_addr_i = 32'h800; stall_i = STALL_MEM;
    tick(); #1;
    chk("rst_pre_req", 32'(dbus.req), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0; mem_aluop_i = OP_NOP; dbus.ack = 1'b1; dbus.rdata = 32'h1234_5678;
    #1;
    chk("rst_mid_req", 32'(dbus.req), 32'd0);
    chk("rst_mid_stall", 32'(stallreq_o), 32'd0);
    tick();
    dbus.ack = 1'b0;
    #1;
    chk("late_ack_req", 32'(dbus.req), 32'd0);
    chk("late_ack_err", 32'(bus_err_o), 32'd0);
    chk("late_ack_wreg", 32'(wb_wreg_o), 32'd1);
    stall_i = 6'b00_0000;

    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
